// File: rtl/wb_result_fifo_pkg.sv
// Shared writeback definitions.
//   XLEN    : architectural data width of a result
//   PREG_W  : physical register tag width
//   wb_pkt_t: tag + data pair carried from an FU to the CDB
package wb_result_fifo_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PREG_W = 6;

  typedef struct packed {
    logic [PREG_W-1:0] tag;
    logic [XLEN-1:0]   data;
  } wb_pkt_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Per-FU writeback buffer between one functional unit and the CDB arbiter.
// Completed results queue here in order; the oldest is held on wb_* until the
// arbiter grants it.
//
// Ports:
//   clk_i         clock
//   rst_i         asynchronous active-high reset
//   flush_i       discard all buffered results
//   push_valid_i  FU presents a result
//   push_ready_o  buffer can accept a result this cycle
//   push_tag_i    destination physical register (0 = x0, dropped)
//   push_data_i   result value
//   wb_valid_o    head entry requests the CDB
//   wb_tag_o      head entry tag (0 when empty)
//   wb_data_o     head entry data (0 when empty)
//   grant_i       arbiter selected this buffer
//   count_o       number of occupied entries
module wb_result_fifo
  import wb_result_fifo_pkg::*;
#(
  parameter int unsigned XLEN_P = XLEN,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [PREG_W-1:0]          push_tag_i,
  input  logic [XLEN_P-1:0]          push_data_i,
  output logic                       wb_valid_o,
  output logic [PREG_W-1:0]          wb_tag_o,
  output logic [XLEN_P-1:0]          wb_data_o,
  input  logic                       grant_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PREG_W-1:0] tag_mem  [DEPTH];
  logic [XLEN_P-1:0] data_mem [DEPTH];

  logic push_acc;
  logic do_store;
  logic do_pop;

  // Ready depends only on registered occupancy, keeping grant_i off this path.
  assign push_ready_o = (count_q < CntW'(DEPTH));
  assign wb_valid_o   = (count_q != '0);
  assign count_o      = count_q;

  assign push_acc = push_valid_i && push_ready_o;
  // x0 results complete the handshake but are never written back.
  assign do_store = push_acc && (push_tag_i != '0);
  assign do_pop   = grant_i && wb_valid_o;

  assign wb_tag_o  = wb_valid_o ? tag_mem[head_q]  : '0;
  assign wb_data_o = wb_valid_o ? data_mem[head_q] : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_store) tail_d = tail_q + PtrW'(1);
      if (do_pop)   head_d = head_q + PtrW'(1);
      count_d = count_q + CntW'(do_store) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (do_store && !flush_i) begin
      tag_mem[tail_q]  <= push_tag_i;
      data_mem[tail_q] <= push_data_i;
    end
  end

endmodule

// File: tb/tb_wb_result_fifo.sv
module tb_wb_result_fifo;
  import wb_result_fifo_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              push_valid;
  logic              push_ready;
  logic [PREG_W-1:0] push_tag;
  logic [XLEN-1:0]   push_data;
  logic              wb_valid;
  logic [PREG_W-1:0] wb_tag;
  logic [XLEN-1:0]   wb_data;
  logic              grant;
  logic [CW-1:0]     count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: a queue of packed {tag, data} results in push order.
  logic [PREG_W+XLEN-1:0] model_q[$];

  always #5 clk = ~clk;

  wb_result_fifo #(
    .XLEN_P(XLEN),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .push_valid_i(push_valid),
    .push_ready_o(push_ready),
    .push_tag_i  (push_tag),
    .push_data_i (push_data),
    .wb_valid_o  (wb_valid),
    .wb_tag_o    (wb_tag),
    .wb_data_o   (wb_data),
    .grant_i     (grant),
    .count_o     (count)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  // Compare all outputs against what the queue says should be visible.
  task automatic chk_model(input string tag);
    logic [PREG_W-1:0] et;
    logic [XLEN-1:0]   ed;
    et = '0;
    ed = '0;
    if (model_q.size() > 0) begin
      et = model_q[0][PREG_W+XLEN-1:XLEN];
      ed = model_q[0][XLEN-1:0];
    end
    chk({tag, ".valid"}, 64'(wb_valid), 64'(model_q.size() != 0));
    chk({tag, ".tag"}, 64'(wb_tag), 64'(et));
    chk({tag, ".data"}, 64'(wb_data), 64'(ed));
    chk({tag, ".count"}, 64'(count), 64'(model_q.size()));
    chk({tag, ".ready"}, 64'(push_ready), 64'(model_q.size() < DEPTH));
  endtask

  // One clock: drive inputs at the falling edge, check pre-edge outputs,
  // then apply the queue semantics for what the edge should do.
  task automatic cycle(input string tag, input logic pv, input logic [PREG_W-1:0] t,
                       input logic [XLEN-1:0] d, input logic g, input logic f);
    bit acc, pop;
    push_valid = pv;
    push_tag   = t;
    push_data  = d;
    grant      = g;
    flush      = f;
    #1;
    chk_model(tag);
    acc = pv && (model_q.size() < DEPTH);
    pop = g && (model_q.size() != 0);
    @(posedge clk);
    if (f) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (acc && t != '0) model_q.push_back({t, d});
    end
    @(negedge clk);
    push_valid = 1'b0;
    grant      = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    push_valid = 1'b0;
    push_tag   = '0;
    push_data  = '0;
    grant      = 1'b0;
    #12;
    chk_model("reset");
    @(negedge clk);
    rst = 1'b0;

    // Grant while empty does nothing.
    cycle("idle_grant", 1'b0, 6'd0, 32'h0, 1'b1, 1'b0);
    chk_model("after_idle_grant");

    // Push then grant, one-cycle latency.
    cycle("push5", 1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("push5.tag", 64'(wb_tag), 64'd5);
    chk("push5.data", 64'(wb_data), 64'hDEADBEEF);
    cycle("grant5", 1'b0, 6'd0, 32'h0, 1'b1, 1'b0);
    chk("grant5.valid", 64'(wb_valid), 64'd0);

    // Fill, refuse when full, wrap the tail, drain in order.
    for (int i = 1; i <= 4; i++) cycle("fill", 1'b1, 6'(i), 32'(i * 16'h1111), 1'b0, 1'b0);
    chk("full.count", 64'(count), 64'd4);
    chk("full.ready", 64'(push_ready), 64'd0);
    cycle("refuse7", 1'b1, 6'd7, 32'h77, 1'b0, 1'b0);
    chk("refuse7.count", 64'(count), 64'd4);
    cycle("pop1", 1'b0, 6'd0, 32'h0, 1'b1, 1'b0);
    chk("pop1.head", 64'(wb_tag), 64'd2);
    chk("pop1.ready", 64'(push_ready), 64'd1);
    cycle("push7", 1'b1, 6'd7, 32'h77, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [PREG_W-1:0] exp_tag [4];
      exp_tag = '{6'd2, 6'd3, 6'd4, 6'd7};
      chk("drain.order", 64'(wb_tag), 64'(exp_tag[i]));
      cycle("drain", 1'b0, 6'd0, 32'h0, 1'b1, 1'b0);
    end
    chk_model("drained");

    // Simultaneous push and pop at count 2.
    cycle("sim_a", 1'b1, 6'd10, 32'hA, 1'b0, 1'b0);
    cycle("sim_b", 1'b1, 6'd11, 32'hB, 1'b0, 1'b0);
    cycle("sim_pp", 1'b1, 6'd12, 32'hC, 1'b1, 1'b0);
    chk("sim.count", 64'(count), 64'd2);
    chk("sim.head", 64'(wb_tag), 64'd11);

    // Full with simultaneous push+pop: push refused, accepted next cycle.
    cycle("fill3", 1'b1, 6'd13, 32'hD, 1'b0, 1'b0);
    cycle("fill4", 1'b1, 6'd14, 32'hE, 1'b0, 1'b0);
    cycle("full_pp", 1'b1, 6'd15, 32'hF, 1'b1, 1'b0);
    chk("full_pp.count", 64'(count), 64'd3);
    cycle("retry15", 1'b1, 6'd15, 32'hF, 1'b0, 1'b0);
    chk("retry15.count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) cycle("drain2", 1'b0, 6'd0, 32'h0, 1'b1, 1'b0);

    // Tag zero is acknowledged but dropped.
    cycle("tag0", 1'b1, 6'd0, 32'h1234, 1'b0, 1'b0);
    chk("tag0.valid", 64'(wb_valid), 64'd0);
    chk("tag0.count", 64'(count), 64'd0);

    // Flush beats a concurrent push and grant.
    for (int i = 0; i < 3; i++) cycle("pre_flush", 1'b1, 6'(20 + i), 32'(i), 1'b0, 1'b0);
    cycle("flush", 1'b1, 6'd9, 32'h9, 1'b1, 1'b1);
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.valid", 64'(wb_valid), 64'd0);

    // Asynchronous reset mid-cycle with entries held.
    cycle("pre_rst_a", 1'b1, 6'd30, 32'h30, 1'b0, 1'b0);
    cycle("pre_rst_b", 1'b1, 6'd31, 32'h31, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    model_q.delete();
    chk_model("async_rst");
    rst = 1'b0;
    @(negedge clk);

    // Randomised traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      logic [PREG_W-1:0] rt;
      rt = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      cycle("rand", 1'($urandom_range(0, 2) != 0), rt, $urandom(),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
    end
    chk_model("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
